btn_conditioner: RTL and testbench
==================================

// Module: btn_conditioner
// PURPOSE
//  Per-button input conditioner between the raw board push-buttons and the LED pattern / mode logic.
//  Synchronises each button, debounces it with a sampled stability counter, and outputs two signals:
//  the clean level and a one-CLK press pulse that the mode-step logic consumes directly.
//  Optional auto-repeat emits extra press pulses while a button is held.
// PARAMETERS
//  NBTN        1          number of independent buttons
//  SAMPLE_DIV  1250000    CLK cycles per sample tick (10 ms at 125 MHz); >=2
//  STABLE_N    3          consecutive differing samples needed to change the debounced level; >=1
//  REPEAT_DLY  50         sample ticks held before the first repeat pulse (BTN_AUTOREPEAT_EN only)
//  REPEAT_PER  10         sample ticks between later repeat pulses (BTN_AUTOREPEAT_EN only)
// PORTS
//  CLK     in   1     system clock; single clock domain
//  RST     in   1     asynchronous, active-low reset
//  BTNIN   in   NBTN  raw asynchronous button inputs, 1 = pressed
//  BTNLVL  out  NBTN  debounced level, registered
//  BTNOUT  out  NBTN  one-CLK press pulse per debounced 0->1 (plus repeats), registered
// BEHAVIOUR
//  - Reset (RST=0, async assert; release is taken at the next CLK edge): sync FFs, prescaler,
//    stability counters, repeat counters, BTNLVL and BTNOUT all go to 0.
//  - Sync: 2-FF synchroniser per bit (s1 <= BTNIN; s2 <= s1). Only s2 is used downstream.
//  - Prescaler: count 0..SAMPLE_DIV-1, then wrap to 0. tick=1 for one CLK when count==SAMPLE_DIV-1.
//    One prescaler is shared by all buttons.
//  - Per button, on a tick cycle only:
//      s2==BTNLVL -> stab cnt <= 0.
//      s2!=BTNLVL and cnt==STABLE_N-1 -> BTNLVL <= s2; cnt <= 0.
//      otherwise -> cnt <= cnt+1.
//    The counter is $clog2(STABLE_N+1) bits wide and never exceeds STABLE_N-1.
//    On non-tick cycles all per-button state holds.
//  - BTNOUT[i] is 1 on exactly the CLK cycle in which BTNLVL[i] first reads 1; 0 in all other cycles.
//    Release (1->0) produces no pulse.
//  - Latency from a clean BTNIN edge to BTNLVL: 2 CLK sync, then STABLE_N ticks
//    (the first of those ticks may be 0..SAMPLE_DIV-1 cycles away).
//  - Bounce: any sample equal to the current level restarts the count.
//    A glitch shorter than STABLE_N ticks never changes BTNLVL.
//  - Buttons are fully independent. Simultaneous presses give simultaneous BTNOUT bits in the same cycle.
//  - Reset mid-press: BTNLVL returns to 0. If the button is still held, a fresh press is detected
//    STABLE_N ticks after reset release, and BTNOUT pulses then.
// CONFIGURATION
//  BTN_AUTOREPEAT_EN defined:
//    - A per-button repeat counter, $clog2(max(REPEAT_DLY,REPEAT_PER)+1) bits, clears while BTNLVL=0.
//    - While BTNLVL=1 it increments on each tick.
//    - When it reaches REPEAT_DLY, BTNOUT pulses for one CLK on that tick cycle.
//    - After that it pulses every REPEAT_PER ticks until release.
//    - Release clears the counter in the same cycle and stops repeats immediately.
//  BTN_AUTOREPEAT_EN undefined:
//    - No repeat logic is generated and REPEAT_* are ignored.
//    - Exactly one BTNOUT pulse per debounced press.
// TESTING (bench params SAMPLE_DIV=4, STABLE_N=3, NBTN=2; repeat tests REPEAT_DLY=5, REPEAT_PER=2)
//  1 Reset: RST=0 with BTNIN=2'b11 -> BTNLVL=0, BTNOUT=0 asynchronously; both stay 0 until 3 ticks after release.
//  2 Clean press: BTNIN[0] 0->1 and held -> BTNLVL[0]=1 after 2 CLK + 3 ticks (<=14 CLK);
//    BTNOUT[0]=1 for exactly 1 CLK; no pulse on the later release.
//  3 Bounce: BTNIN[0] high for 2 ticks, low 1 tick, then high -> no BTNLVL change during the bounce;
//    a single BTNOUT pulse 3 ticks after the final rise.
//  4 Independence: BTNIN=2'b11 applied in the same cycle -> BTNOUT=2'b11 in the same cycle, once;
//    pressing btn1 while btn0 is held -> only BTNOUT[1] pulses.
//  5 Reset mid-hold: RST pulsed low while BTNLVL[0]=1 and BTNIN[0] still held -> BTNLVL drops to 0;
//    a new BTNOUT pulse 3 ticks after reset release.
//  6 Auto-repeat (macro on): hold btn0 -> pulses at level rise, then +5, +7, +9 ticks;
//    release at +8 -> no pulse at +9.
//    Macro off -> exactly 1 pulse for the same stimulus.

Source files
------------

// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-FF sync, tick-sampled debounce, registered level and press pulse.
// Define BTN_AUTOREPEAT_EN to add auto-repeat press pulses while a button stays held.
module btn_conditioner #(
    parameter int unsigned NBTN       = 1,
    parameter int unsigned SAMPLE_DIV = 1250000,
    parameter int unsigned STABLE_N   = 3,
    parameter int unsigned REPEAT_DLY = 50,
    parameter int unsigned REPEAT_PER = 10
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NBTN-1:0] BTNIN,
    output logic [NBTN-1:0] BTNLVL,
    output logic [NBTN-1:0] BTNOUT
);

    localparam int unsigned PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned SW = $clog2(STABLE_N + 1);
    localparam logic [PW-1:0] P_LAST = PW'(SAMPLE_DIV - 1);
    localparam logic [SW-1:0] S_LAST = SW'(STABLE_N - 1);

    logic [NBTN-1:0]         s1;
    logic [NBTN-1:0]         s2;
    logic [PW-1:0]           pcnt;
    logic                    tick_c;
    logic [NBTN-1:0][SW-1:0] scnt;
    logic [NBTN-1:0][SW-1:0] scnt_nxt;
    logic [NBTN-1:0]         lvl_nxt;
    logic [NBTN-1:0]         rise_c;
    logic [NBTN-1:0]         pulse_c;

    assign tick_c = (pcnt == P_LAST);

    // Stability counter: a sample matching the current level restarts the count.
    always_comb begin
        scnt_nxt = scnt;
        lvl_nxt  = BTNLVL;
        rise_c   = '0;
        if (tick_c) begin
            for (int unsigned i = 0; i < NBTN; i++) begin
                if (s2[i] == BTNLVL[i]) begin
                    scnt_nxt[i] = '0;
                end else if (scnt[i] == S_LAST) begin
                    lvl_nxt[i]  = s2[i];
                    scnt_nxt[i] = '0;
                    rise_c[i]   = s2[i];
                end else begin
                    scnt_nxt[i] = scnt[i] + SW'(1);
                end
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int unsigned RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] R_DLY = RW'(REPEAT_DLY);
    localparam logic [RW-1:0] R_PER = RW'(REPEAT_PER);

    logic [NBTN-1:0][RW-1:0] rcnt;
    logic [NBTN-1:0][RW-1:0] rcnt_nxt;
    logic [NBTN-1:0]         rphase;
    logic [NBTN-1:0]         rphase_nxt;
    logic [NBTN-1:0]         rep_c;

    // rphase selects the initial delay (0) or the steady repeat period (1).
    always_comb begin
        rcnt_nxt   = rcnt;
        rphase_nxt = rphase;
        rep_c      = '0;
        for (int unsigned i = 0; i < NBTN; i++) begin
            if (!BTNLVL[i] || !lvl_nxt[i]) begin
                rcnt_nxt[i]   = '0;
                rphase_nxt[i] = 1'b0;
            end else if (tick_c) begin
                if ((rcnt[i] + RW'(1)) == (rphase[i] ? R_PER : R_DLY)) begin
                    rep_c[i]      = 1'b1;
                    rcnt_nxt[i]   = '0;
                    rphase_nxt[i] = 1'b1;
                end else begin
                    rcnt_nxt[i] = rcnt[i] + RW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rcnt   <= '0;
            rphase <= '0;
        end else begin
            rcnt   <= rcnt_nxt;
            rphase <= rphase_nxt;
        end
    end

    assign pulse_c = rise_c | rep_c;
`else
    logic unused_rep;
    assign unused_rep = ^{32'(REPEAT_DLY), 32'(REPEAT_PER)};
    assign pulse_c    = rise_c;
`endif

    // Synchroniser, shared prescaler and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1     <= '0;
            s2     <= '0;
            pcnt   <= '0;
            scnt   <= '0;
            BTNLVL <= '0;
            BTNOUT <= '0;
        end else begin
            s1     <= BTNIN;
            s2     <= s1;
            pcnt   <= tick_c ? '0 : pcnt + PW'(1);
            scnt   <= scnt_nxt;
            BTNLVL <= lvl_nxt;
            BTNOUT <= pulse_c;
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed vector table plus random stimulus against a sample-history model.
module tb_btn_conditioner;

    localparam int NB = 2;
    localparam int SD = 4;
    localparam int SN = 3;
    localparam int RD = 5;
    localparam int RP = 2;
`ifdef BTN_AUTOREPEAT_EN
    localparam int REP = 1;
`else
    localparam int REP = 0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [NB-1:0] BTNIN = '0;
    logic [NB-1:0] BTNLVL;
    logic [NB-1:0] BTNOUT;

    btn_conditioner #(
        .NBTN      (NB),
        .SAMPLE_DIV(SD),
        .STABLE_N  (SN),
        .REPEAT_DLY(RD),
        .REPEAT_PER(RP)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .BTNIN (BTNIN),
        .BTNLVL(BTNLVL),
        .BTNOUT(BTNOUT)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model: debounced level flips once the last SN tick samples all disagree with it.
    logic [NB-1:0] m_d1, m_d2, m_lvl, m_out;
    logic [SN-1:0] m_hist [NB];
    int            m_held [NB];
    int            m_e;

    initial begin
        m_d1 = '0; m_d2 = '0; m_lvl = '0; m_out = '0; m_e = 0;
        for (int i = 0; i < NB; i++) begin
            m_hist[i] = '0;
            m_held[i] = 0;
        end
    end

    task automatic model_edge();
        logic [NB-1:0] s2_old;
        bit            tick;
        if (!RST) begin
            m_d1 = '0; m_d2 = '0; m_lvl = '0; m_out = '0; m_e = 0;
            for (int i = 0; i < NB; i++) begin
                m_hist[i] = '0;
                m_held[i] = 0;
            end
        end else begin
            tick   = ((m_e % SD) == SD - 1);
            m_e    = m_e + 1;
            s2_old = m_d2;
            m_d2   = m_d1;
            m_d1   = BTNIN;
            m_out  = '0;
            if (tick) begin
                for (int i = 0; i < NB; i++) begin
                    m_hist[i] = {m_hist[i][SN-2:0], s2_old[i]};
                    if (m_hist[i] == {SN{~m_lvl[i]}}) begin
                        m_lvl[i] = ~m_lvl[i];
                        if (m_lvl[i]) begin
                            m_out[i]  = 1'b1;
                            m_held[i] = 0;
                        end
                    end else if (m_lvl[i]) begin
                        m_held[i] = m_held[i] + 1;
                        if (REP != 0 && (m_held[i] == RD ||
                            (m_held[i] > RD && ((m_held[i] - RD) % RP) == 0)))
                            m_out[i] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0d expected=%0d", name, $time, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_edge();
        #1;
        check("model_lvl", int'(BTNLVL), int'(m_lvl));
        check("model_out", int'(BTNOUT), int'(m_out));
    endtask

    typedef struct {
        int rst;
        int btn;
        int cyc;
        int lvl;
        int p0;
        int p1;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int c0, c1, mode, thr;

        // {rst, btn, cycles, level at end, btn0 pulses, btn1 pulses}
        tbl.push_back('{0, 3,  3, 0, 0, 0});
        tbl.push_back('{1, 3, 11, 0, 0, 0});
        tbl.push_back('{1, 3,  1, 3, 1, 1});
        tbl.push_back('{1, 0, 11, 3, 0, 0});
        tbl.push_back('{1, 0,  1, 0, 0, 0});
        tbl.push_back('{1, 1, 11, 0, 0, 0});
        tbl.push_back('{1, 1,  1, 1, 1, 0});
        tbl.push_back('{1, 3, 11, 1, 0, 0});
        tbl.push_back('{1, 3,  1, 3, 0, 1});
        tbl.push_back('{1, 0, 11, 3, REP, 0});
        tbl.push_back('{1, 0,  1, 0, 0, 0});
        tbl.push_back('{1, 1,  8, 0, 0, 0});
        tbl.push_back('{1, 0,  4, 0, 0, 0});
        tbl.push_back('{1, 1, 11, 0, 0, 0});
        tbl.push_back('{1, 1,  1, 1, 1, 0});
        tbl.push_back('{1, 0, 11, 1, 0, 0});
        tbl.push_back('{1, 0,  1, 0, 0, 0});
        tbl.push_back('{1, 1, 12, 1, 1, 0});
        tbl.push_back('{0, 1,  3, 0, 0, 0});
        tbl.push_back('{1, 1, 11, 0, 0, 0});
        tbl.push_back('{1, 1,  1, 1, 1, 0});
        tbl.push_back('{1, 0, 11, 1, 0, 0});
        tbl.push_back('{1, 0,  1, 0, 0, 0});
        tbl.push_back('{1, 1, 11, 0, 0, 0});
        tbl.push_back('{1, 1,  1, 1, 1, 0});
        tbl.push_back('{1, 1, 20, 1, REP, 0});
        tbl.push_back('{1, 0, 11, 1, REP, 0});
        tbl.push_back('{1, 0,  1, 0, 0, 0});
        tbl.push_back('{1, 0,  8, 0, 0, 0});

        #1;
        for (int k = 0; k < tbl.size(); k++) begin
            RST   = 1'(tbl[k].rst);
            BTNIN = 2'(tbl[k].btn);
            if (tbl[k].rst == 0) begin
                // Reset must clear the outputs before any clock edge arrives.
                #1;
                check("async_rst_lvl", int'(BTNLVL), 0);
                check("async_rst_out", int'(BTNOUT), 0);
            end
            c0 = 0;
            c1 = 0;
            for (int n = 0; n < tbl[k].cyc; n++) begin
                cycle();
                c0 += int'(BTNOUT[0]);
                c1 += int'(BTNOUT[1]);
            end
            check($sformatf("vec%0d_lvl", k), int'(BTNLVL), tbl[k].lvl);
            check($sformatf("vec%0d_pulse0", k), c0, tbl[k].p0);
            check($sformatf("vec%0d_pulse1", k), c1, tbl[k].p1);
        end

        RST   = 1'b0;
        BTNIN = '0;
        cycle();
        cycle();
        RST  = 1'b1;
        mode = 0;
        for (int n = 0; n < 4000; n++) begin
            if (n % 64 == 0) mode = int'($urandom_range(0, 2));
            thr = (mode == 0) ? 3 : (mode == 1) ? 20 : 200;
            RST = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            for (int b = 0; b < NB; b++)
                if ($urandom_range(0, thr - 1) == 0) BTNIN[b] = ~BTNIN[b];
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
